// File: rtl/mod_cmp_pkg.sv
// Shared sign encoding and compare/merge helpers for the dual-threshold
// mixed-radix comparator.
package mod_cmp_pkg;

    typedef logic [1:0] sign_t;

    localparam sign_t SIGN_EQ  = 2'b00;
    localparam sign_t SIGN_GT  = 2'b01;
    localparam sign_t SIGN_LT  = 2'b10;
    localparam sign_t SIGN_ERR = 2'b11;

    // Widest digit the compare helper handles; callers zero-extend into it.
    localparam int CMP_W = 64;

    // Any decided (or illegal) prior sign wins over this stage's digit result.
    function automatic sign_t sign_merge(input sign_t prior, input sign_t nxt);
        return (prior != SIGN_EQ) ? prior : nxt;
    endfunction

    function automatic sign_t digit_cmp(input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b);
        if (a > b) return SIGN_GT;
        if (a < b) return SIGN_LT;
        return SIGN_EQ;
    endfunction

endpackage

// File: rtl/mod_cmp_stage.sv
// One comparator pipeline stage: compares a single digit against the POS and
// NEG constant digits and merges with the signs from more-significant stages.
module mod_cmp_stage
    import mod_cmp_pkg::*;
#(
    parameter int                    DATA_WIDTH = 18,
    parameter logic [DATA_WIDTH-1:0] POS_DIGIT  = '0,
    parameter logic [DATA_WIDTH-1:0] NEG_DIGIT  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] digit,
    input  sign_t                 sign_a_in,
    input  sign_t                 sign_b_in,
    output logic                  valid_out,
    output sign_t                 sign_a_out,
    output sign_t                 sign_b_out
);

    sign_t cmp_a;
    sign_t cmp_b;

    assign cmp_a = digit_cmp(CMP_W'(digit), CMP_W'(POS_DIGIT));
    assign cmp_b = digit_cmp(CMP_W'(digit), CMP_W'(NEG_DIGIT));

    // Stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            sign_a_out <= SIGN_EQ;
            sign_b_out <= SIGN_EQ;
        end else if (en) begin
            valid_out  <= valid_in;
            sign_a_out <= sign_merge(sign_a_in, cmp_a);
            sign_b_out <= sign_merge(sign_b_in, cmp_b);
        end
    end

endmodule

// File: rtl/mod_dual_cmp_nl.sv
// Pipelined dual-threshold comparator for mixed-radix digit vectors with a
// valid/ready handshake, global stall and an output alignment delay line.
module mod_dual_cmp_nl
    import mod_cmp_pkg::*;
#(
    parameter int                                DATA_WIDTH  = 18,
    parameter int                                NUM_DIGITS  = 4,
    parameter logic [NUM_DIGITS*DATA_WIDTH-1:0]  POS_DIGITS  = '0,
    parameter logic [NUM_DIGITS*DATA_WIDTH-1:0]  NEG_DIGITS  = '0,
    parameter int                                ALIGN_DEPTH = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_DIGITS*DATA_WIDTH-1:0] in_digits,
    input  logic [1:0]                       sign_in_A,
    input  logic [1:0]                       sign_in_B,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [1:0]                       sign_result_A,
    output logic [1:0]                       sign_result_B,
    output logic                             pos_cout,
    output logic                             neg_cout
);

    localparam int VEC_W = NUM_DIGITS * DATA_WIDTH;

    // Bit offset of stage k's digit slice inside the triangular digit bus;
    // stage k sees only the NUM_DIGITS-k digits not yet consumed.
    function automatic int src_off(input int k);
        return DATA_WIDTH * (k * NUM_DIGITS - (k * (k - 1)) / 2);
    endfunction

    localparam int SRC_W = src_off(NUM_DIGITS);

    logic             en;
    logic             vld_p0;
    sign_t            sa_p0;
    sign_t            sb_p0;
    logic [VEC_W-1:0] dig_p0;

    wire [SRC_W-1:0]              src_bus;
    wire [NUM_DIGITS:0]           vld_st;
    wire [NUM_DIGITS:0][1:0]      sa_st;
    wire [NUM_DIGITS:0][1:0]      sb_st;
    wire [ALIGN_DEPTH:0]          vld_al;
    wire [ALIGN_DEPTH:0][1:0]     sa_al;
    wire [ALIGN_DEPTH:0][1:0]     sb_al;

    // Every stage, bubbles included, holds while the output is blocked.
    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;

    // Stage 0: input capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            sa_p0  <= SIGN_EQ;
            sb_p0  <= SIGN_EQ;
        end else if (en) begin
            vld_p0 <= in_valid;
            sa_p0  <= sign_in_A;
            sb_p0  <= sign_in_B;
        end
    end

    always_ff @(posedge clk) begin
        if (en) dig_p0 <= in_digits;
    end

    assign vld_st[0]          = vld_p0;
    assign sa_st[0]           = sa_p0;
    assign sb_st[0]           = sb_p0;
    assign src_bus[0 +: VEC_W] = dig_p0;

    // Stages 1..NUM_DIGITS: one digit per stage, most significant first
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_stg
        localparam int OFF = src_off(k);
        localparam int SW  = (NUM_DIGITS - k) * DATA_WIDTH;

        mod_cmp_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .POS_DIGIT  (POS_DIGITS[k*DATA_WIDTH +: DATA_WIDTH]),
            .NEG_DIGIT  (NEG_DIGITS[k*DATA_WIDTH +: DATA_WIDTH])
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .valid_in   (vld_st[k]),
            .digit      (src_bus[OFF +: DATA_WIDTH]),
            .sign_a_in  (sa_st[k]),
            .sign_b_in  (sb_st[k]),
            .valid_out  (vld_st[k+1]),
            .sign_a_out (sa_st[k+1]),
            .sign_b_out (sb_st[k+1])
        );

        if (k < NUM_DIGITS - 1) begin : g_rest
            logic [SW-DATA_WIDTH-1:0] rest_p;

            always_ff @(posedge clk) begin
                if (en) rest_p <= src_bus[OFF+DATA_WIDTH +: SW-DATA_WIDTH];
            end

            assign src_bus[OFF+SW +: SW-DATA_WIDTH] = rest_p;
        end
    end

    // Alignment delay line
    assign vld_al[0] = vld_st[NUM_DIGITS];
    assign sa_al[0]  = sa_st[NUM_DIGITS];
    assign sb_al[0]  = sb_st[NUM_DIGITS];

    for (genvar j = 0; j < ALIGN_DEPTH; j++) begin : g_align
        logic  vld_q;
        sign_t sa_q;
        sign_t sb_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                sa_q  <= SIGN_EQ;
                sb_q  <= SIGN_EQ;
            end else if (en) begin
                vld_q <= vld_al[j];
                sa_q  <= sa_al[j];
                sb_q  <= sb_al[j];
            end
        end

        assign vld_al[j+1] = vld_q;
        assign sa_al[j+1]  = sa_q;
        assign sb_al[j+1]  = sb_q;
    end

    assign out_valid     = vld_al[ALIGN_DEPTH];
    assign sign_result_A = sa_al[ALIGN_DEPTH];
    assign sign_result_B = sb_al[ALIGN_DEPTH];
    assign pos_cout      = |sa_al[ALIGN_DEPTH];
    assign neg_cout      = |sb_al[ALIGN_DEPTH];

endmodule

// File: tb/tb_mod_dual_cmp_nl.sv
// Directed bench for mod_dual_cmp_nl: a 3-digit byte instance for the main
// scenarios plus 1-digit and 16-digit instances for the parameter corners.
module tb_mod_dual_cmp_nl;

    localparam logic [23:0]  POS3  = 24'h102030;
    localparam logic [23:0]  NEG3  = 24'h050000;
    localparam logic [7:0]   POS1  = 8'h80;
    localparam logic [7:0]   NEG1  = 8'h20;
    localparam logic [127:0] POS16 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] NEG16 = 128'h00FF_00FF_00FF_00FF_00FF_00FF_00FF_00FF;
    localparam int L   = 1 + 3 + 5;
    localparam int L1  = 1 + 1 + 0;
    localparam int L16 = 1 + 16 + 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [23:0] in_digits = '0;
    logic [1:0]  sign_in_A = '0, sign_in_B = '0, sign_result_A, sign_result_B;
    logic        pos_cout, neg_cout;

    logic         c_valid = 1'b0, c_ordy = 1'b1;
    logic [1:0]   c_pa = '0, c_pb = '0;
    logic [7:0]   c1_dig = '0;
    logic [127:0] c16_dig = '0;
    logic         c1_ready, c1_ovalid, c1_pc, c1_nc;
    logic         c16_ready, c16_ovalid, c16_pc, c16_nc;
    logic [1:0]   c1_sa, c1_sb, c16_sa, c16_sb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mod_dual_cmp_nl #(.DATA_WIDTH(8), .NUM_DIGITS(3), .POS_DIGITS(POS3),
                      .NEG_DIGITS(NEG3), .ALIGN_DEPTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_digits(in_digits), .sign_in_A(sign_in_A), .sign_in_B(sign_in_B),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_result_A(sign_result_A), .sign_result_B(sign_result_B),
        .pos_cout(pos_cout), .neg_cout(neg_cout));

    mod_dual_cmp_nl #(.DATA_WIDTH(8), .NUM_DIGITS(1), .POS_DIGITS(POS1),
                      .NEG_DIGITS(NEG1), .ALIGN_DEPTH(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c1_ready),
        .in_digits(c1_dig), .sign_in_A(c_pa), .sign_in_B(c_pb),
        .out_valid(c1_ovalid), .out_ready(c_ordy),
        .sign_result_A(c1_sa), .sign_result_B(c1_sb),
        .pos_cout(c1_pc), .neg_cout(c1_nc));

    mod_dual_cmp_nl #(.DATA_WIDTH(8), .NUM_DIGITS(16), .POS_DIGITS(POS16),
                      .NEG_DIGITS(NEG16), .ALIGN_DEPTH(15)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c16_ready),
        .in_digits(c16_dig), .sign_in_A(c_pa), .sign_in_B(c_pb),
        .out_valid(c16_ovalid), .out_ready(c_ordy),
        .sign_result_A(c16_sa), .sign_result_B(c16_sb),
        .pos_cout(c16_pc), .neg_cout(c16_nc));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk digits from index 0 (most significant), first decided sign sticks.
    function automatic logic [5:0] model(input logic [127:0] dig, input logic [127:0] pos,
                                         input logic [127:0] neg, input int n,
                                         input logic [1:0] pa, input logic [1:0] pb);
        logic [1:0] a, b;
        logic [7:0] d, p, q;
        a = pa;
        b = pb;
        for (int k = 0; k < n; k++) begin
            d = dig[k*8 +: 8];
            p = pos[k*8 +: 8];
            q = neg[k*8 +: 8];
            if (a == 2'b00) a = (d > p) ? 2'b01 : ((d < p) ? 2'b10 : 2'b00);
            if (b == 2'b00) b = (d > q) ? 2'b01 : ((d < q) ? 2'b10 : 2'b00);
        end
        return {a, b, |a, |b};
    endfunction

    function automatic logic [5:0] obs_main();
        return {sign_result_A, sign_result_B, pos_cout, neg_cout};
    endfunction

    // One word in, checks quiet before L edges, the result at L, and no repeat after.
    task automatic run_one(input string tag, input logic [23:0] d, input logic [1:0] pa,
                           input logic [1:0] pb, input logic [5:0] exp_o);
        @(negedge clk);
        in_digits = d;
        sign_in_A = pa;
        sign_in_B = pb;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (L - 2) @(posedge clk);
        #1 check({tag, "_early"}, out_valid, 0);
        @(posedge clk);
        #1 check({tag, "_valid"}, out_valid, 1);
        check(tag, obs_main(), exp_o);
        @(posedge clk);
        #1 check({tag, "_nodup"}, out_valid, 0);
    endtask

    logic [23:0] w_dig [20];
    logic [1:0]  w_pa  [20];
    logic [1:0]  w_pb  [20];
    logic [5:0]  w_exp [20];
    logic [5:0]  q1 [$];
    logic [5:0]  q16 [$];
    int          qt1 [$];
    int          qt16 [$];

    initial begin
        int sent, recv, t;
        logic [5:0] e;
        logic [127:0] pos16_v, neg16_v, v;
        logic [7:0] pos1_v, neg1_v, b1;

        // Reset state, before any clock edge
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_signs", obs_main(), 6'h00);
        check("rst_in_ready", in_ready, 1);
        check("rst_c16_valid", c16_ovalid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("equal",       24'h102030, 2'b00, 2'b00, 6'h05);
        run_one("msd_lt",      24'h0F200F, 2'b00, 2'b00, 6'h27);
        run_one("msd_gt",      24'h0F2031, 2'b00, 2'b00, 6'h17);
        run_one("lsd_decides", 24'h112030, 2'b00, 2'b00, 6'h17);
        run_one("neg_equal",   24'h050000, 2'b00, 2'b00, 6'h22);
        run_one("prior_dom",   24'h102030, 2'b01, 2'b11, 6'h1F);
        run_one("prior_lt",    24'h102030, 2'b10, 2'b00, 6'h27);
        run_one("prior_err",   24'h050000, 2'b11, 2'b00, 6'h32);

        // Back-to-back stream with a 4-cycle downstream stall
        for (int i = 0; i < 20; i++) begin
            w_dig[i] = 24'($urandom);
            w_pa[i]  = 2'($urandom_range(0, 3));
            w_pb[i]  = 2'($urandom_range(0, 3));
            if (i % 4 == 0) w_dig[i] = POS3;
            if (i % 5 == 1) w_dig[i] = NEG3;
            w_exp[i] = model(128'(w_dig[i]), 128'(POS3), 128'(NEG3), 3, w_pa[i], w_pb[i]);
        end
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 200 && recv < 20; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 12 && cyc <= 15);
            in_valid  = (sent < 20);
            if (sent < 20) begin
                in_digits = w_dig[sent];
                sign_in_A = w_pa[sent];
                sign_in_B = w_pb[sent];
            end
            #1;
            check("stream_in_ready", in_ready, !(out_valid && !out_ready));
            if (cyc >= 12 && cyc <= 15) check("stall_hold", in_ready, 0);
            if (out_valid && out_ready) begin
                check($sformatf("stream_%0d", recv), obs_main(), w_exp[recv]);
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", recv, 20);
        repeat (12) begin
            @(negedge clk);
            check("stream_nodup", out_valid, 0);
        end

        // Asynchronous reset with words in flight
        @(negedge clk);
        in_digits = 24'h102030;
        sign_in_A = 2'b01;
        sign_in_B = 2'b10;
        in_valid  = 1'b1;
        repeat (6) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (L - 6) @(posedge clk);
        #1 check("arst_pre_valid", out_valid, 1);
        check("arst_pre_data", obs_main(), 6'h1B);
        #2 rst_n = 1'b0;
        #1 check("arst_valid", out_valid, 0);
        check("arst_signs", obs_main(), 6'h00);
        check("arst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("arst_no_stale", out_valid, 0);
        end
        run_one("arst_next", 24'h0F200F, 2'b00, 2'b00, 6'h27);

        // Parameter corners: 1 digit / no alignment, 16 digits / 15 alignment
        pos16_v = POS16;
        neg16_v = NEG16;
        pos1_v  = POS1;
        neg1_v  = NEG1;
        for (int cyc = 0; cyc < 1100; cyc++) begin
            @(negedge clk);
            #1;
            if (c1_ovalid) begin
                if (q1.size() == 0) check("c1_spurious", c1_ovalid, 0);
                else begin
                    e = q1.pop_front();
                    t = qt1.pop_front();
                    check("c1_data", {c1_sa, c1_sb, c1_pc, c1_nc}, e);
                    check("c1_latency", cyc - t, L1);
                end
            end
            if (c16_ovalid) begin
                if (q16.size() == 0) check("c16_spurious", c16_ovalid, 0);
                else begin
                    e = q16.pop_front();
                    t = qt16.pop_front();
                    check("c16_data", {c16_sa, c16_sb, c16_pc, c16_nc}, e);
                    check("c16_latency", cyc - t, L16);
                end
            end
            if (cyc < 1000) begin
                c_pa = 2'($urandom_range(0, 3));
                c_pb = 2'($urandom_range(0, 3));
                for (int k = 0; k < 16; k++) begin
                    case ($urandom_range(0, 3))
                        0:       v[k*8 +: 8] = pos16_v[k*8 +: 8];
                        1:       v[k*8 +: 8] = neg16_v[k*8 +: 8];
                        default: v[k*8 +: 8] = 8'($urandom);
                    endcase
                end
                case ($urandom_range(0, 3))
                    0:       b1 = pos1_v;
                    1:       b1 = neg1_v;
                    default: b1 = 8'($urandom);
                endcase
                c16_dig = v;
                c1_dig  = b1;
                c_valid = 1'b1;
                q1.push_back(model(128'(b1), 128'(POS1), 128'(NEG1), 1, c_pa, c_pb));
                qt1.push_back(cyc);
                q16.push_back(model(v, POS16, NEG16, 16, c_pa, c_pb));
                qt16.push_back(cyc);
            end else begin
                c_valid = 1'b0;
            end
        end
        check("c1_drain", q1.size(), 0);
        check("c16_drain", q16.size(), 0);
        check("corner_ready", {c1_ready, c16_ready}, 2'b11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
